// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - icache/dcache arbiter and single-word burst sequencer for the external memory port
module mem_arb #(
    parameter int ICACHE_LINE_SIZE = 64,
    parameter int DCACHE_LINE_SIZE = 64
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      ic_req,
    input  logic [31:0]                               ic_addr,
    output logic                                      ic_gnt,
    output logic                                      ic_rvalid,
    output logic [31:0]                               ic_rdata,
    output logic [$clog2(ICACHE_LINE_SIZE/4)-1:0]     ic_ridx,
    output logic                                      ic_done,
    input  logic                                      dc_req,
    input  logic                                      dc_we,
    input  logic [31:0]                               dc_addr,
    output logic                                      dc_gnt,
    output logic                                      dc_rvalid,
    output logic [31:0]                               dc_rdata,
    output logic [$clog2(DCACHE_LINE_SIZE/4)-1:0]     dc_ridx,
    output logic                                      dc_done,
    output logic [$clog2(DCACHE_LINE_SIZE/4)-1:0]     dc_widx,
    input  logic [31:0]                               dc_wdata,
    output logic                                      mem_req,
    output logic                                      mem_we,
    output logic [31:0]                               mem_addr,
    output logic [31:0]                               mem_wdata,
    input  logic [31:0]                               mem_rdata,
    input  logic                                      mem_ack
);
    localparam int IC_N  = ICACHE_LINE_SIZE / 4;
    localparam int DC_N  = DCACHE_LINE_SIZE / 4;
    localparam int IC_IW = $clog2(IC_N);
    localparam int DC_IW = $clog2(DC_N);
    localparam int IW    = (IC_IW > DC_IW) ? IC_IW : DC_IW;

    localparam logic [IW-1:0] IC_LAST = IW'(IC_N - 1);
    localparam logic [IW-1:0] DC_LAST = IW'(DC_N - 1);
    localparam logic [31:0]   IC_MASK = ~(32'(ICACHE_LINE_SIZE) - 32'd1);
    localparam logic [31:0]   DC_MASK = ~(32'(DCACHE_LINE_SIZE) - 32'd1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state;
    logic          sel_dc;
    logic          we_r;
    logic          last_dc;
    logic [31:0]   base;
    logic [IW-1:0] idx;

    logic bursting;
    logic last_word;
    logic pick_dc;

    // Memory-side outputs decode straight from flops, so they are clean and zero outside BURST.
    assign bursting  = (state == BURST);
    assign mem_req   = bursting;
    assign mem_we    = bursting & we_r;
    assign mem_addr  = bursting ? (base | {{(30-IW){1'b0}}, idx, 2'b00}) : 32'd0;
    assign mem_wdata = mem_we ? dc_wdata : 32'd0;
    assign dc_widx   = (bursting && sel_dc) ? idx[DC_IW-1:0] : '0;

    assign last_word = (idx == (sel_dc ? DC_LAST : IC_LAST));
    // On a tie the client that was not granted last wins.
    assign pick_dc   = dc_req && (!ic_req || !last_dc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_dc    <= 1'b0;
            we_r      <= 1'b0;
            last_dc   <= 1'b0;
            base      <= 32'd0;
            idx       <= '0;
            ic_gnt    <= 1'b0;
            ic_rvalid <= 1'b0;
            ic_rdata  <= 32'd0;
            ic_ridx   <= '0;
            ic_done   <= 1'b0;
            dc_gnt    <= 1'b0;
            dc_rvalid <= 1'b0;
            dc_rdata  <= 32'd0;
            dc_ridx   <= '0;
            dc_done   <= 1'b0;
        end else begin
            ic_gnt    <= 1'b0;
            dc_gnt    <= 1'b0;
            ic_rvalid <= 1'b0;
            dc_rvalid <= 1'b0;
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        state   <= BURST;
                        sel_dc  <= pick_dc;
                        last_dc <= pick_dc;
                        idx     <= '0;
                        if (pick_dc) begin
                            dc_gnt <= 1'b1;
                            base   <= dc_addr & DC_MASK;
                            we_r   <= dc_we;
                        end else begin
                            ic_gnt <= 1'b1;
                            base   <= ic_addr & IC_MASK;
                            we_r   <= 1'b0;
                        end
                    end
                end
                BURST: begin
                    if (mem_ack) begin
                        idx <= idx + IW'(1);
                        if (!we_r) begin
                            if (sel_dc) begin
                                dc_rvalid <= 1'b1;
                                dc_rdata  <= mem_rdata;
                                dc_ridx   <= idx[DC_IW-1:0];
                            end else begin
                                ic_rvalid <= 1'b1;
                                ic_rdata  <= mem_rdata;
                                ic_ridx   <= idx[IC_IW-1:0];
                            end
                        end
                        if (last_word) begin
                            state <= DONE;
                            if (sel_dc) begin
                                dc_done <= 1'b1;
                            end else begin
                                ic_done <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, ic_gnt, ic_rvalid, ic_done;
    logic [31:0] ic_addr, ic_rdata;
    logic [3:0]  ic_ridx;
    logic        dc_req, dc_we, dc_gnt, dc_rvalid, dc_done;
    logic [31:0] dc_addr, dc_rdata, dc_wdata;
    logic [3:0]  dc_ridx, dc_widx;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int   errors = 0;
    int   checks = 0;
    int   wait_n = 0;
    int   wait_cnt = 0;
    logic force_ack = 1'b0;

    mem_arb #(.ICACHE_LINE_SIZE(64), .DCACHE_LINE_SIZE(64)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_ridx(ic_ridx), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_gnt(dc_gnt),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_ridx(dc_ridx), .dc_done(dc_done),
        .dc_widx(dc_widx), .dc_wdata(dc_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Memory model: ack after wait_n stall cycles; read data tags the word index.
    assign mem_ack   = force_ack | (mem_req && (wait_cnt >= wait_n));
    assign mem_rdata = 32'hA000_0000 | {28'd0, mem_addr[5:2]};
    assign dc_wdata  = 32'h5500_0000 | {28'd0, dc_widx};

    always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {24'd0, ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done,
                              mem_req, mem_we}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ic_rdata"}, ic_rdata, 32'd0);
        check({tag, "_dc_rdata"}, dc_rdata, 32'd0);
        check({tag, "_idx"}, {20'd0, ic_ridx, dc_ridx, dc_widx}, 32'd0);
    endtask

    // Starts in the grant cycle and returns in the done cycle.
    task automatic watch_burst(input bit is_dc, input bit exp_we, input logic [31:0] base,
                               input int waits, input string tag);
        int acks = 0;
        int rvs = 0;
        int hold = 0;
        int last_ack = -10;
        bit fin = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (mem_req) begin
                hold++;
                check({tag, "_addr"}, mem_addr, base + 32'(4 * acks));
                check({tag, "_we"}, {31'd0, mem_we}, {31'd0, exp_we});
                if (exp_we) begin
                    check({tag, "_widx"}, {28'd0, dc_widx}, 32'(acks));
                    check({tag, "_wdata"}, mem_wdata, 32'h5500_0000 | 32'(acks));
                end
                if (mem_ack) begin
                    check({tag, "_hold"}, 32'(hold), 32'(waits + 1));
                    acks++;
                    hold = 0;
                    last_ack = c;
                end
            end
            if (is_dc ? dc_rvalid : ic_rvalid) begin
                if (exp_we) begin
                    check({tag, "_no_rvalid"}, 32'd1, 32'd0);
                end else begin
                    check({tag, "_ridx"}, {28'd0, is_dc ? dc_ridx : ic_ridx}, 32'(rvs));
                    check({tag, "_rdata"}, is_dc ? dc_rdata : ic_rdata, 32'hA000_0000 | 32'(rvs));
                end
                rvs++;
            end
            if (is_dc ? dc_done : ic_done) begin
                check({tag, "_done_lat"}, 32'(c), 32'(last_ack + 1));
                check({tag, "_acks"}, 32'(acks), 32'd16);
                check({tag, "_rvs"}, 32'(rvs), exp_we ? 32'd0 : 32'd16);
                fin = 1;
            end
            if (!fin) step();
        end
        if (!fin) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int seq[3];
        int ng;
        int n;
        rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = 32'd0; dc_addr = 32'd0;
        step(); step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // Icache refill, zero-wait memory, then stray acks in DONE and IDLE.
        ic_addr = 32'h0000_1234; ic_req = 1'b1;
        step();
        check("ic_gnt", {31'd0, ic_gnt}, 32'd1);
        check("ic_gnt_memreq", {31'd0, mem_req}, 32'd1);
        check("ic_gnt_only", {31'd0, dc_gnt}, 32'd0);
        ic_req = 1'b0;
        watch_burst(0, 0, 32'h0000_1200, 0, "ic");
        force_ack = 1'b1;
        step();
        check("stray_done", {29'd0, mem_req, ic_rvalid, ic_done}, 32'd0);
        step();
        check("stray_idle", {29'd0, mem_req, ic_rvalid, ic_gnt}, 32'd0);
        force_ack = 1'b0;
        step();

        // Dcache writeback with two wait cycles per word.
        wait_n = 2;
        dc_addr = 32'h8000_0040; dc_we = 1'b1; dc_req = 1'b1;
        step();
        check("wb_gnt", {30'd0, dc_gnt, mem_we}, 32'd3);
        dc_req = 1'b0; dc_we = 1'b0;
        watch_burst(1, 1, 32'h8000_0040, 2, "wb");
        wait_n = 0;
        step();

        // Tie after reset: dcache first, icache granted two cycles after dc_done.
        rst = 1'b1; step(); rst = 1'b0;
        ic_addr = 32'h0000_3000; dc_addr = 32'h0000_4000;
        ic_req = 1'b1; dc_req = 1'b1;
        step();
        check("tie_first", {30'd0, dc_gnt, ic_gnt}, 32'd2);
        dc_req = 1'b0;
        watch_burst(1, 0, 32'h0000_4000, 0, "tie_dc");
        step();
        check("tie_gap", {31'd0, ic_gnt}, 32'd0);
        step();
        check("tie_ic_gnt", {31'd0, ic_gnt}, 32'd1);
        ic_req = 1'b0;
        watch_burst(0, 0, 32'h0000_3000, 0, "tie_ic");
        step();

        // Both requests held: grants alternate dcache, icache, dcache.
        rst = 1'b1; step(); rst = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        ng = 0;
        for (int c = 0; c < 300 && ng < 3; c++) begin
            step();
            if (ic_gnt && dc_gnt) check("alt_both_gnt", 32'd1, 32'd0);
            if (dc_gnt) begin seq[ng] = 1; ng++; end
            else if (ic_gnt) begin seq[ng] = 0; ng++; end
        end
        check("alt_count", 32'(ng), 32'd3);
        check("alt_seq", {29'd0, 1'(seq[0]), 1'(seq[1]), 1'(seq[2])}, 32'd5);
        ic_req = 1'b0; dc_req = 1'b0;

        // Reset mid-burst after five acks, then a fresh refill restarts at word 0.
        rst = 1'b1; step(); rst = 1'b0;
        ic_addr = 32'h0000_5000; ic_req = 1'b1;
        step();
        ic_req = 1'b0;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            if (mem_ack) n++;
            if (n == 5) break;
            step();
        end
        check("mid_acks", 32'(n), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("mid_rst");
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_no_done", {30'd0, ic_done, mem_req}, 32'd0);
        end
        ic_addr = 32'h0000_6040; ic_req = 1'b1;
        step();
        check("restart_gnt", {31'd0, ic_gnt}, 32'd1);
        ic_req = 1'b0;
        watch_burst(0, 0, 32'h0000_6040, 0, "restart");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
# mem_arb

Unified-memory arbiter and burst sequencer between the instruction cache, the data cache and the core's single external memory port. It accepts whole-line refill requests from the icache and line refill or writeback requests from the dcache. Each granted request becomes a sequence of single-word transfers on the memory port. Returned read words stream back to the requesting cache, one per cycle at most.

## Interface
- ICACHE_LINE_SIZE, 64, icache line size in bytes; power of two, ≥ 8.
- DCACHE_LINE_SIZE, 64, dcache line size in bytes; power of two, ≥ 8.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- ic_req  in  1  icache line-read request (level).
- ic_addr  in  32  icache line address; low log2(ICACHE_LINE_SIZE) bits are ignored.
- ic_gnt  out  1  one-cycle pulse: icache request accepted, address latched.
- ic_rvalid  out  1  one-cycle pulse: ic_rdata/ic_ridx valid.
- ic_rdata  out  32  read word.
- ic_ridx  out  log2(ICACHE_LINE_SIZE/4)  word index within the line.
- ic_done  out  1  one-cycle pulse: line complete.
- dc_req, dc_we, dc_addr  in  1/1/32  dcache request; we=1 means line write, we=0 means line read.
- dc_gnt, dc_rvalid, dc_rdata, dc_ridx, dc_done  out  —  same as the icache ports, with dcache widths.
- dc_widx  out  log2(DCACHE_LINE_SIZE/4)  index of the word being written.
- dc_wdata  in  32  write word; combinational function of dc_widx.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid in the mem_ack cycle.
- mem_ack  in  1  transfer complete.

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - If a request is pending, the arbiter grants one client: the *_gnt pulse, the latched line base and the latched dc_we are all registered on the transition to BURST.
  - If both clients request, the grant goes to the client not granted last. The `last` register resets to icache, so the dcache wins the first tie after reset.
- BURST:
  - mem_req=1.
  - mem_addr = base + 4·idx.
  - mem_we = latched we (always 0 for the icache).
  - mem_wdata = dc_wdata.
  - dc_widx = idx.
  - On mem_ack, idx increments. If idx was the last word (N−1, with N = LINE_SIZE/4), go to DONE.
- DONE: *_done pulses for one cycle, then the FSM returns to IDLE.
  - No grant is made in DONE, so consecutive bursts are separated by one DONE and one IDLE cycle.
- Read return: on a mem_ack during a read, the next cycle has *_rvalid=1 with the registered rdata and idx. The final rvalid coincides with the *_done cycle.
- Write: the dcache must hold dc_wdata stable for the current dc_widx; the arbiter advances dc_widx only on mem_ack.
- Clients:
  - A client drops req the cycle after its gnt unless it issues a new request.
  - A req held or re-raised after gnt is treated as a new request and is served only after the current burst completes.
  - Client address and we are sampled only at grant.
- Address: base = addr with its low line bits zeroed. idx is log2(N) bits and never wraps within a burst, so no carry reaches beyond the line bits.
- mem_ack while mem_req=0 (IDLE/DONE): ignored.
- Reset asserted in any state, including mid-burst:
  - Next state is IDLE.
  - idx=0.
  - `last` = icache.
  - All outputs are 0 from the next cycle.
  - The remainder of the interrupted burst is abandoned; no done pulse is issued.

## Timing
- Reset values: every output 0 (mem_req, mem_we, mem_addr, mem_wdata, all gnt/rvalid/done, rdata, ridx, widx).
- Request to mem_req:
  - req is sampled high in IDLE at edge k.
  - gnt is high in cycle k+1, with state=BURST and mem_req high in the same cycle.
- Memory handshake: mem_req, mem_addr, mem_we and mem_wdata are held stable until the cycle mem_ack=1; the next word is presented the following cycle (zero-bubble streaming).
- With zero-wait memory (ack every cycle in which mem_req=1), a burst takes N cycles of mem_req, then 1 DONE cycle, then 1 IDLE cycle.
- Read data latency: mem_ack cycle to *_rvalid is 1 cycle.
- Simultaneous req from both clients in IDLE: exactly one gnt is issued.

## Test plan
- Icache refill, 64-byte line, ic_addr=0x0000_1234, zero-wait ack, mem_rdata=0xA000_0000+idx -> the following must hold:
  - mem_addr = 0x1200, 0x1204, …, 0x123C.
  - 16 ic_rvalid with ic_ridx 0..15 and data 0xA000_0000..0xA000_000F.
  - ic_done together with the last rvalid.
- Dcache writeback, dc_addr=0x8000_0040, dc_wdata=0x5500_0000|dc_widx, ack after 2 wait cycles per word -> the following must hold:
  - 16 writes with mem_we=1 and mem_addr 0x8000_0040..0x8000_007C.
  - Each word is held 3 cycles.
  - No dc_rvalid.
  - dc_done after the 16th ack.
- ic_req and dc_req raised in the same cycle after reset -> dc_gnt first, full dcache burst, then ic_gnt two cycles after dc_done.
- dc_req held high continuously with ic_req also high -> grants alternate dcache, icache, dcache; no starvation.
- rst pulsed after 5 acks of a read burst -> all outputs 0 next cycle, no done pulse; a fresh ic_req afterwards restarts at word 0 of the new line.
- mem_ack pulsed while IDLE and during DONE -> no state change, no rvalid, idx unchanged.
